// File: rtl/chdr_data_deframer_pkg.sv
// chdr_data_deframer_pkg: CHDR header layout, packet type codes and deframer states.
package chdr_data_deframer_pkg;
  typedef struct packed {
    logic [5:0]  vc;
    logic        eob;
    logic        eov;
    logic [2:0]  pkt_type;
    logic [4:0]  num_mdata;
    logic [15:0] seq_num;
    logic [15:0] length;
    logic [15:0] dst_epid;
  } chdr_header_t;
  localparam logic [2:0] PKT_TYPE_DATA_NO_TS          = 3'd6;
  localparam logic [2:0] PKT_TYPE_DATA_WITH_TIMESTAMP = 3'd7;
  typedef enum logic [2:0] {ST_HDR, ST_TS, ST_MDATA, ST_PYLD, ST_EMPTY, ST_DROP} deframer_state_t;
  function automatic logic [15:0] chdr_hdr_overhead_bytes(input logic has_time, input logic [4:0] num_mdata);
    return (16'(num_mdata) + 16'(has_time) + 16'd1) << 3;
  endfunction
endpackage

// File: rtl/chdr_data_deframer_hdr_decode.sv
// chdr_data_deframer_hdr_decode: combinational unpack of a CHDR header word plus payload size.
module chdr_data_deframer_hdr_decode
  import chdr_data_deframer_pkg::*;
(
  input  logic [63:0] hdr,
  output logic        eob,
  output logic        eov,
  output logic        is_data,
  output logic        has_time,
  output logic [4:0]  num_mdata,
  output logic [15:0] seq_num,
  output logic [15:0] pyld_bytes,
  output logic [12:0] words
);
  chdr_header_t h;
  logic [15:0] ovh;
  logic [16:0] len_rnd;
  logic unused;
  assign h = chdr_header_t'(hdr);
  assign unused = ^{h.vc, h.dst_epid, len_rnd[16], len_rnd[2:0]};
  assign eob = h.eob;
  assign eov = h.eov;
  assign is_data = h.pkt_type == PKT_TYPE_DATA_NO_TS || h.pkt_type == PKT_TYPE_DATA_WITH_TIMESTAMP;
  assign has_time = h.pkt_type == PKT_TYPE_DATA_WITH_TIMESTAMP;
  assign num_mdata = h.num_mdata;
  assign seq_num = h.seq_num;
  assign ovh = chdr_hdr_overhead_bytes(has_time, h.num_mdata);
  // A length shorter than the overhead is malformed; report no payload rather than wrap.
  assign pyld_bytes = h.length > ovh ? h.length - ovh : '0;
  assign len_rnd = {1'b0, h.length} + 17'd7;
  assign words = len_rnd[15:3];
endmodule

// File: rtl/chdr_data_deframer.sv
// chdr_data_deframer: strips CHDR header/timestamp/metadata and forwards payload with sideband context.
// Define CHDR_DEFRAMER_MDATA_EN to expose metadata words on an m_mdata_* stream instead of discarding them.
module chdr_data_deframer
  import chdr_data_deframer_pkg::*;
#(
  parameter int CHDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              chdr_clk,
  input  logic              chdr_rst,
  input  logic [CHDR_W-1:0] s_chdr_tdata,
  input  logic              s_chdr_tlast,
  input  logic              s_chdr_tvalid,
  output logic              s_chdr_tready,
  output logic [CHDR_W-1:0] m_pyld_tdata,
  output logic [7:0]        m_pyld_tkeep,
  output logic              m_pyld_tlast,
  output logic              m_pyld_tvalid,
  input  logic              m_pyld_tready,
  output logic [15:0]       m_seq_num,
  output logic              m_eob,
  output logic              m_eov,
  output logic              m_has_time,
  output logic [63:0]       m_timestamp,
  output logic [15:0]       m_pyld_bytes,
`ifdef CHDR_DEFRAMER_MDATA_EN
  output logic [63:0]       m_mdata_tdata,
  output logic              m_mdata_tlast,
  output logic              m_mdata_tvalid,
  input  logic              m_mdata_tready,
`endif
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  err_count
);
  deframer_state_t state, state_nxt;
  logic rdy, ended, hs, mdata_rdy, dec_eob, dec_eov, dec_data, dec_has_time;
  logic [4:0] dec_nmd, md_cnt;
  logic [15:0] dec_seq, dec_bytes;
  logic [12:0] dec_words, exp_words, wcnt, beats, exp_cur;
  logic [2:0] rem;
  if (CHDR_W != 64) begin : g_w_check
    $fatal(1, "chdr_data_deframer: only CHDR_W = 64 is supported");
  end
  chdr_data_deframer_hdr_decode u_dec (
    .hdr(s_chdr_tdata[63:0]), .eob(dec_eob), .eov(dec_eov), .is_data(dec_data),
    .has_time(dec_has_time), .num_mdata(dec_nmd), .seq_num(dec_seq),
    .pyld_bytes(dec_bytes), .words(dec_words)
  );
  assign hs = s_chdr_tvalid & s_chdr_tready;
  assign beats = state == ST_HDR ? 13'd1 : wcnt + 13'd1;
  assign exp_cur = state == ST_HDR ? dec_words : exp_words;
  assign rem = m_pyld_bytes[2:0];
  always_ff @(posedge chdr_clk or posedge chdr_rst)
    if (chdr_rst) state <= ST_HDR;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR:   if (hs) state_nxt = !dec_data ? (s_chdr_tlast ? ST_HDR : ST_DROP) :
                                    s_chdr_tlast ? ST_EMPTY : dec_has_time ? ST_TS :
                                    dec_nmd != 5'd0 ? ST_MDATA : dec_bytes == 16'd0 ? ST_EMPTY : ST_PYLD;
      ST_TS:    if (hs) state_nxt = s_chdr_tlast ? ST_EMPTY : md_cnt != 5'd0 ? ST_MDATA :
                                    m_pyld_bytes == 16'd0 ? ST_EMPTY : ST_PYLD;
      ST_MDATA: if (hs && (s_chdr_tlast || md_cnt == 5'd1))
                  state_nxt = s_chdr_tlast || m_pyld_bytes == 16'd0 ? ST_EMPTY : ST_PYLD;
      ST_PYLD:  if (hs && s_chdr_tlast) state_nxt = ST_HDR;
      ST_EMPTY: if (m_pyld_tready) state_nxt = ended ? ST_HDR : ST_DROP;
      ST_DROP:  if (hs && s_chdr_tlast) state_nxt = ST_HDR;
      default:  state_nxt = ST_HDR;
    endcase
  end
  // ST_EMPTY is the synthetic zero-byte beat; it consumes no input.
  always_comb begin
    s_chdr_tready = rdy && (state == ST_PYLD ? m_pyld_tready : state == ST_MDATA ? mdata_rdy : state != ST_EMPTY);
    m_pyld_tvalid = state == ST_PYLD ? s_chdr_tvalid : state == ST_EMPTY;
    m_pyld_tdata  = state == ST_PYLD ? s_chdr_tdata : '0;
    m_pyld_tlast  = state == ST_PYLD ? s_chdr_tlast : state == ST_EMPTY;
    m_pyld_tkeep  = state != ST_PYLD ? 8'h00 : s_chdr_tlast && rem != 3'd0 ? 8'hFF >> (4'd8 - {1'b0, rem}) : 8'hFF;
  end
`ifdef CHDR_DEFRAMER_MDATA_EN
  assign mdata_rdy = m_mdata_tready;
  assign m_mdata_tvalid = state == ST_MDATA && s_chdr_tvalid;
  assign m_mdata_tdata = state == ST_MDATA ? s_chdr_tdata[63:0] : '0;
  assign m_mdata_tlast = state == ST_MDATA && (md_cnt == 5'd1 || s_chdr_tlast);
`else
  assign mdata_rdy = 1'b1;
`endif
  always_ff @(posedge chdr_clk or posedge chdr_rst)
    if (chdr_rst) begin
      rdy <= 1'b0;
      ended <= 1'b0;
      md_cnt <= '0;
      wcnt <= '0;
      exp_words <= '0;
      m_seq_num <= '0;
      m_eob <= 1'b0;
      m_eov <= 1'b0;
      m_has_time <= 1'b0;
      m_timestamp <= '0;
      m_pyld_bytes <= '0;
      drop_count <= '0;
      err_count <= '0;
    end else begin
      rdy <= 1'b1;
      if (hs) begin
        wcnt <= beats;
        if (s_chdr_tlast && beats != exp_cur) err_count <= err_count + 1'b1;
        if (state == ST_HDR || state == ST_TS || state == ST_MDATA) ended <= s_chdr_tlast;
      end
      if (hs && state == ST_HDR) begin
        exp_words <= dec_words;
        if (dec_data) begin
          m_seq_num <= dec_seq;
          m_eob <= dec_eob;
          m_eov <= dec_eov;
          m_has_time <= dec_has_time;
          m_timestamp <= '0;
          m_pyld_bytes <= dec_bytes;
          md_cnt <= dec_nmd;
        end else drop_count <= drop_count + 1'b1;
      end
      if (hs && state == ST_TS) m_timestamp <= s_chdr_tdata[63:0];
      if (hs && state == ST_MDATA) md_cnt <= md_cnt - 5'd1;
    end
endmodule
